// File: rtl/gcd_operand_sequencer_if.sv
// Bundles the operand stream, the core load/control bus and the result stream
// of the GCD operand sequencer so they can be passed as a single port.
interface gcd_operand_sequencer_if #(
  parameter int W = 16
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic [W-1:0] core_data;
  logic         core_start;
  logic         core_clr;
  logic         core_done;
  logic [W-1:0] core_result;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_gcd;
  logic         out_err;
  logic         busy;

  // Environment side: producer of operands, the core itself, and the result consumer.
  modport master (
    output in_valid, in_a, in_b, core_done, core_result, out_ready,
    input  in_ready, core_data, core_start, core_clr, out_valid, out_gcd, out_err, busy
  );

  // Sequencer side.
  modport slave (
    input  in_valid, in_a, in_b, core_done, core_result, out_ready,
    output in_ready, core_data, core_start, core_clr, out_valid, out_gcd, out_err, busy
  );
endinterface

// File: rtl/gcd_operand_sequencer.sv
// Feeds operand pairs to a subtractive GCD core over its shared load bus
// (A with start, then B), waits for done with a timeout, clears the core and
// returns the result on a valid/ready stream. Zero operands bypass the core,
// since the subtractive algorithm never terminates on them.
module gcd_operand_sequencer #(
  parameter int W       = 16,
  parameter int TIMEOUT = 1023,
  parameter int CW      = 10
) (
  input  logic                   clk,
  input  logic                   rst_n,
  gcd_operand_sequencer_if.slave bus
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD_A = 3'd1;
  localparam logic [2:0] S_LOAD_B = 3'd2;
  localparam logic [2:0] S_WAIT   = 3'd3;
  localparam logic [2:0] S_CLEAR  = 3'd4;
  localparam logic [2:0] S_RESP   = 3'd5;

  localparam logic [CW-1:0] LAST_WAIT = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_MAX   = '1;

  logic [2:0]    r_state;
  logic [W-1:0]  r_a;
  logic [W-1:0]  r_b;
  logic [CW-1:0] r_cnt;
  logic [W-1:0]  r_gcd;
  logic          r_err;

  logic          w_accept;
  logic          w_zero;
  logic          w_timeout;
  logic [W-1:0]  w_core_data;

  assign w_accept  = bus.in_valid && (r_state == S_IDLE);
  assign w_zero    = (bus.in_a == '0) || (bus.in_b == '0);
  assign w_timeout = (r_cnt == LAST_WAIT);

  // Job sequencing: accept, bypass zeros, load A/B, wait with timeout, clear, respond.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_cnt   <= '0;
      r_gcd   <= '0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_a <= bus.in_a;
            r_b <= bus.in_b;
            if (w_zero) begin
              r_gcd   <= bus.in_a | bus.in_b;
              r_err   <= 1'b0;
              r_state <= S_RESP;
            end else begin
              r_state <= S_LOAD_A;
            end
          end
        end
        S_LOAD_A: r_state <= S_LOAD_B;
        S_LOAD_B: begin
          r_cnt   <= '0;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (r_cnt != CNT_MAX) begin
            r_cnt <= r_cnt + 1'b1;
          end
          if (bus.core_done) begin
            r_gcd   <= bus.core_result;
            r_err   <= 1'b0;
            r_state <= S_CLEAR;
          end else if (w_timeout) begin
            r_gcd   <= '0;
            r_err   <= 1'b1;
            r_state <= S_CLEAR;
          end
        end
        S_CLEAR: r_state <= S_RESP;
        S_RESP: begin
          if (bus.out_ready) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Load bus carries A during the start cycle, then B until the core is cleared.
  always_comb begin
    w_core_data = '0;
    case (r_state)
      S_LOAD_A:         w_core_data = r_a;
      S_LOAD_B, S_WAIT: w_core_data = r_b;
      default:          w_core_data = '0;
    endcase
  end

  assign bus.core_data  = w_core_data;
  assign bus.core_start = (r_state == S_LOAD_A);
  assign bus.core_clr   = (r_state == S_CLEAR);
  assign bus.in_ready   = (r_state == S_IDLE);
  assign bus.busy       = (r_state != S_IDLE);
  assign bus.out_valid  = (r_state == S_RESP);
  assign bus.out_gcd    = r_gcd;
  assign bus.out_err    = r_err;

endmodule

// File: tb/tb_gcd_operand_sequencer.sv
// Directed bench for gcd_operand_sequencer with a behavioural subtractive core
// whose done latency is set per job.
module tb_gcd_operand_sequencer;

  localparam int W = 16;

  logic clk;
  logic rst_n;
  int   testCount;
  int   failCount;
  int   coreDelay;
  logic spurDone;

  logic [W-1:0] mCa;
  logic [W-1:0] mRes;
  logic         mLoadB;
  logic         mRunning;
  int           mCnt;

  gcd_operand_sequencer_if #(.W(W)) bus();

  gcd_operand_sequencer #(.W(W), .TIMEOUT(8), .CW(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // 10-unit clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference GCD by repeated subtraction; zero inputs never reach the core.
  function automatic logic [W-1:0] refGcd(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] x;
    logic [W-1:0] y;
    x = a;
    y = b;
    if (x == '0 || y == '0) return x | y;
    while (x != y) begin
      if (x > y) x = x - y;
      else       y = y - x;
    end
    return x;
  endfunction

  // Behavioural core: latch A on start, B next cycle, done coreDelay cycles after B is on the bus.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mCa      <= '0;
      mRes     <= '0;
      mLoadB   <= 1'b0;
      mRunning <= 1'b0;
      mCnt     <= 0;
    end else begin
      if (bus.core_clr) mRunning <= 1'b0;
      if (bus.core_start) begin
        mCa    <= bus.core_data;
        mLoadB <= 1'b1;
      end else begin
        mLoadB <= 1'b0;
      end
      if (mLoadB) begin
        mRes     <= refGcd(mCa, bus.core_data);
        mRunning <= 1'b1;
        mCnt     <= (coreDelay > 0) ? coreDelay - 1 : 0;
      end else if (mRunning && mCnt > 0) begin
        mCnt <= mCnt - 1;
      end
    end
  end

  assign bus.core_done   = (mRunning && mCnt == 0 && coreDelay != 0) || spurDone;
  assign bus.core_result = mRes;

  // Present one operand pair and return just after the accept edge.
  task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_a     = a;
    bus.in_b     = b;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  // Observe cycles 1..limit after accept; cycle 1 is the cycle right after the accept edge.
  task automatic waitResult(input int limit, output int vCyc, output int clrCyc, output int startCnt,
                            output logic [W-1:0] d1, output logic [W-1:0] d2,
                            output logic s1, output logic s2);
    vCyc = -1; clrCyc = -1; startCnt = 0;
    d1 = '0; d2 = '0; s1 = 1'b0; s2 = 1'b0;
    for (int n = 1; n <= limit; n++) begin
      @(negedge clk);
      if (n == 1) begin d1 = bus.core_data; s1 = bus.core_start; end
      if (n == 2) begin d2 = bus.core_data; s2 = bus.core_start; end
      if (bus.core_start) startCnt++;
      if (bus.core_clr && clrCyc < 0) clrCyc = n;
      if (bus.out_valid) begin
        vCyc = n;
        break;
      end
    end
  endtask

  // Complete the output handshake for one cycle.
  task automatic consume();
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    testCount++; if (bus.in_ready !== 1'b1) begin failCount++; $display("[TB] FAIL reset_in_ready got %b expected 1", bus.in_ready); end
    testCount++; if (bus.busy !== 1'b0) begin failCount++; $display("[TB] FAIL reset_busy got %b expected 0", bus.busy); end
    testCount++; if (bus.out_valid !== 1'b0) begin failCount++; $display("[TB] FAIL reset_out_valid got %b expected 0", bus.out_valid); end
    testCount++; if (bus.out_gcd !== 16'd0) begin failCount++; $display("[TB] FAIL reset_out_gcd got %0d expected 0", bus.out_gcd); end
    testCount++; if (bus.out_err !== 1'b0) begin failCount++; $display("[TB] FAIL reset_out_err got %b expected 0", bus.out_err); end
    testCount++; if (bus.core_start !== 1'b0) begin failCount++; $display("[TB] FAIL reset_core_start got %b expected 0", bus.core_start); end
    testCount++; if (bus.core_clr !== 1'b0) begin failCount++; $display("[TB] FAIL reset_core_clr got %b expected 0", bus.core_clr); end
    testCount++; if (bus.core_data !== 16'd0) begin failCount++; $display("[TB] FAIL reset_core_data got %0d expected 0", bus.core_data); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_nonzero();
    int v, c, s;
    logic [W-1:0] d1, d2;
    logic s1, s2;
    coreDelay = 5;
    applyStimulus(16'd12, 16'd18);
    waitResult(20, v, c, s, d1, d2, s1, s2);
    testCount++; if (d1 !== 16'd12) begin failCount++; $display("[TB] FAIL nz_data_a got %0d expected 12", d1); end
    testCount++; if (s1 !== 1'b1) begin failCount++; $display("[TB] FAIL nz_start_c1 got %b expected 1", s1); end
    testCount++; if (d2 !== 16'd18) begin failCount++; $display("[TB] FAIL nz_data_b got %0d expected 18", d2); end
    testCount++; if (s2 !== 1'b0) begin failCount++; $display("[TB] FAIL nz_start_c2 got %b expected 0", s2); end
    testCount++; if (c != 8) begin failCount++; $display("[TB] FAIL nz_clr_cycle got %0d expected 8", c); end
    testCount++; if (v != 9) begin failCount++; $display("[TB] FAIL nz_valid_cycle got %0d expected 9", v); end
    testCount++; if (bus.out_gcd !== 16'd6) begin failCount++; $display("[TB] FAIL nz_gcd got %0d expected 6", bus.out_gcd); end
    testCount++; if (bus.out_err !== 1'b0) begin failCount++; $display("[TB] FAIL nz_err got %b expected 0", bus.out_err); end
    consume();
    @(negedge clk);
    testCount++; if (bus.out_valid !== 1'b0) begin failCount++; $display("[TB] FAIL nz_valid_drop got %b expected 0", bus.out_valid); end
    testCount++; if (bus.in_ready !== 1'b1) begin failCount++; $display("[TB] FAIL nz_in_ready got %b expected 1", bus.in_ready); end
  endtask

  task automatic test_zero_bypass();
    logic [W-1:0] aVec [3] = '{16'd0, 16'd9, 16'd0};
    logic [W-1:0] bVec [3] = '{16'd7, 16'd0, 16'd0};
    logic [W-1:0] gVec [3] = '{16'd7, 16'd9, 16'd0};
    int v, c, s;
    logic [W-1:0] d1, d2;
    logic s1, s2;
    coreDelay = 3;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(aVec[i], bVec[i]);
      waitResult(10, v, c, s, d1, d2, s1, s2);
      testCount++; if (v != 1) begin failCount++; $display("[TB] FAIL zero%0d_valid_cycle got %0d expected 1", i, v); end
      testCount++; if (bus.out_gcd !== gVec[i]) begin failCount++; $display("[TB] FAIL zero%0d_gcd got %0d expected %0d", i, bus.out_gcd, gVec[i]); end
      testCount++; if (bus.out_err !== 1'b0) begin failCount++; $display("[TB] FAIL zero%0d_err got %b expected 0", i, bus.out_err); end
      testCount++; if (s != 0) begin failCount++; $display("[TB] FAIL zero%0d_start got %0d pulses expected 0", i, s); end
      consume();
    end
  endtask

  task automatic test_timeout();
    int v, c, s;
    logic [W-1:0] d1, d2;
    logic s1, s2;
    coreDelay = 0;
    applyStimulus(16'd5, 16'd3);
    waitResult(30, v, c, s, d1, d2, s1, s2);
    testCount++; if (c != 11) begin failCount++; $display("[TB] FAIL to_clr_cycle got %0d expected 11", c); end
    testCount++; if (v != 12) begin failCount++; $display("[TB] FAIL to_valid_cycle got %0d expected 12", v); end
    testCount++; if (bus.out_err !== 1'b1) begin failCount++; $display("[TB] FAIL to_err got %b expected 1", bus.out_err); end
    testCount++; if (bus.out_gcd !== 16'd0) begin failCount++; $display("[TB] FAIL to_gcd got %0d expected 0", bus.out_gcd); end
    consume();
  endtask

  task automatic test_back_pressure();
    int v, c, s;
    logic [W-1:0] d1, d2;
    logic s1, s2;
    coreDelay = 2;
    applyStimulus(16'd8, 16'd12);
    waitResult(20, v, c, s, d1, d2, s1, s2);
    testCount++; if (v != 6) begin failCount++; $display("[TB] FAIL bp_valid_cycle got %0d expected 6", v); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      testCount++; if (bus.out_valid !== 1'b1) begin failCount++; $display("[TB] FAIL bp_valid_hold%0d got %b expected 1", i, bus.out_valid); end
      testCount++; if (bus.out_gcd !== 16'd4) begin failCount++; $display("[TB] FAIL bp_gcd_hold%0d got %0d expected 4", i, bus.out_gcd); end
      testCount++; if (bus.out_err !== 1'b0) begin failCount++; $display("[TB] FAIL bp_err_hold%0d got %b expected 0", i, bus.out_err); end
      testCount++; if (bus.in_ready !== 1'b0) begin failCount++; $display("[TB] FAIL bp_in_ready%0d got %b expected 0", i, bus.in_ready); end
    end
    consume();
    @(negedge clk);
    testCount++; if (bus.in_ready !== 1'b1) begin failCount++; $display("[TB] FAIL bp_in_ready_after got %b expected 1", bus.in_ready); end
    testCount++; if (bus.out_valid !== 1'b0) begin failCount++; $display("[TB] FAIL bp_valid_after got %b expected 0", bus.out_valid); end
  endtask

  task automatic test_spurious_done();
    int v, c, s;
    logic [W-1:0] d1, d2;
    logic s1, s2;
    @(negedge clk);
    spurDone = 1'b1;
    @(negedge clk);
    @(negedge clk);
    spurDone = 1'b0;
    testCount++; if (bus.busy !== 1'b0) begin failCount++; $display("[TB] FAIL spur_busy got %b expected 0", bus.busy); end
    testCount++; if (bus.out_valid !== 1'b0) begin failCount++; $display("[TB] FAIL spur_valid got %b expected 0", bus.out_valid); end
    testCount++; if (bus.in_ready !== 1'b1) begin failCount++; $display("[TB] FAIL spur_in_ready got %b expected 1", bus.in_ready); end
    coreDelay = 8;
    applyStimulus(16'd27, 16'd18);
    waitResult(30, v, c, s, d1, d2, s1, s2);
    testCount++; if (v != 12) begin failCount++; $display("[TB] FAIL coinc_valid_cycle got %0d expected 12", v); end
    testCount++; if (bus.out_gcd !== 16'd9) begin failCount++; $display("[TB] FAIL coinc_gcd got %0d expected 9", bus.out_gcd); end
    testCount++; if (bus.out_err !== 1'b0) begin failCount++; $display("[TB] FAIL coinc_err got %b expected 0", bus.out_err); end
    consume();
  endtask

  task automatic test_reset_mid_job();
    int v, c, s;
    logic [W-1:0] d1, d2;
    logic s1, s2;
    coreDelay = 0;
    applyStimulus(16'd12, 16'd18);
    repeat (4) @(negedge clk);
    testCount++; if (bus.busy !== 1'b1) begin failCount++; $display("[TB] FAIL mid_busy_before got %b expected 1", bus.busy); end
    #2;
    rst_n = 1'b0;
    #1;
    testCount++; if (bus.busy !== 1'b0) begin failCount++; $display("[TB] FAIL mid_busy got %b expected 0", bus.busy); end
    testCount++; if (bus.in_ready !== 1'b1) begin failCount++; $display("[TB] FAIL mid_in_ready got %b expected 1", bus.in_ready); end
    testCount++; if (bus.core_data !== 16'd0) begin failCount++; $display("[TB] FAIL mid_core_data got %0d expected 0", bus.core_data); end
    testCount++; if (bus.core_clr !== 1'b0) begin failCount++; $display("[TB] FAIL mid_core_clr got %b expected 0", bus.core_clr); end
    testCount++; if (bus.out_valid !== 1'b0) begin failCount++; $display("[TB] FAIL mid_out_valid got %b expected 0", bus.out_valid); end
    testCount++; if (bus.out_gcd !== 16'd0 || bus.out_err !== 1'b0) begin failCount++; $display("[TB] FAIL mid_out_data got %0d/%b expected 0/0", bus.out_gcd, bus.out_err); end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    coreDelay = 3;
    applyStimulus(16'd21, 16'd14);
    waitResult(20, v, c, s, d1, d2, s1, s2);
    testCount++; if (v != 7) begin failCount++; $display("[TB] FAIL post_valid_cycle got %0d expected 7", v); end
    testCount++; if (bus.out_gcd !== 16'd7) begin failCount++; $display("[TB] FAIL post_gcd got %0d expected 7", bus.out_gcd); end
    testCount++; if (bus.out_err !== 1'b0) begin failCount++; $display("[TB] FAIL post_err got %b expected 0", bus.out_err); end
    consume();
  endtask

  // Test sequence
  initial begin
    testCount     = 0;
    failCount     = 0;
    coreDelay     = 0;
    spurDone      = 1'b0;
    rst_n         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.out_ready = 1'b0;
    #1;
    test_reset();
    test_nonzero();
    test_zero_bypass();
    test_timeout();
    test_back_pressure();
    test_spurious_done();
    test_reset_mid_job();
    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

  // Global time limit so the bench always terminates
  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired at time %0t", $time);
    $fatal(1, "[TB] watchdog");
  end

endmodule
